// File: rtl/matriz_pkg.sv
// Shared definitions for the dot-matrix key path: code widths, scan FSM states
// and the row/column code pair exchanged with the display decoder.
package matriz_pkg;

    localparam int CODE_W = 3;
    localparam logic [CODE_W-1:0] CODE_NONE = 3'd0;

    typedef enum logic {
        DRIVE  = 1'b0,
        SAMPLE = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [CODE_W-1:0] row;
        logic [CODE_W-1:0] col;
    } code_pair_t;

    localparam code_pair_t CODE_PAIR_NONE = '{row: CODE_NONE, col: CODE_NONE};

endpackage

// File: rtl/matriz_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous level inputs.
module matriz_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the raw lines into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/matriz_scanner.sv
// Key-matrix scanner: drives one column at a time, samples synchronized rows,
// debounces whole-scan results and presents the first pressed key as a code pair.
module matriz_scanner
    import matriz_pkg::*;
#(
    parameter int N_COLS         = 5,
    parameter int N_ROWS         = 7,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_ROWS-1:0] row_in,
    output logic [N_COLS-1:0] col_out,
    output logic [CODE_W-1:0] code_row,
    output logic [CODE_W-1:0] code_col,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              key_down,
    output logic              overflow
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CODE_W-1:0] COL_LAST    = CODE_W'(N_COLS - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX     = DEB_W'(DEBOUNCE_SCANS);

    // Lowest active row as index+1, CODE_NONE when no row is active.
    function automatic logic [CODE_W-1:0] first_row(input logic [N_ROWS-1:0] rows);
        logic [CODE_W-1:0] r;
        r = CODE_NONE;
        for (int i = N_ROWS - 1; i >= 0; i--) begin
            if (rows[i]) begin
                r = CODE_W'(i + 1);
            end
        end
        return r;
    endfunction

    function automatic logic [N_COLS-1:0] col_onehot(input logic [CODE_W-1:0] idx);
        logic [N_COLS-1:0] v;
        v = '0;
        for (int i = 0; i < N_COLS; i++) begin
            if (idx == CODE_W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    logic [N_ROWS-1:0] row_sync_s;
    scan_state_t       state_r, state_s;
    logic              run_r;
    logic [SET_W-1:0]  settle_r, settle_s;
    logic [CODE_W-1:0] col_idx_r, col_idx_s;
    logic [N_COLS-1:0] col_out_r, col_out_s;
    code_pair_t        cand_r, cand_s;
    code_pair_t        scan_s;
    logic [CODE_W-1:0] hit_row_s;
    logic              eos_s;
    code_pair_t        prev_r, prev_s;
    logic [DEB_W-1:0]  stable_r, stable_s;
    code_pair_t        reported_r, reported_s;
    code_pair_t        code_r, code_s;
    logic              code_valid_r, code_valid_s;
    logic              key_down_r, key_down_s;
    logic              overflow_r, overflow_s;

    matriz_sync2 #(.WIDTH(N_ROWS)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_in),
        .q     (row_sync_s)
    );

    // Candidate including the column being sampled this cycle; earlier columns win.
    always_comb begin
        hit_row_s = first_row(row_sync_s);
        if (cand_r.row == CODE_NONE && hit_row_s != CODE_NONE) begin
            scan_s = '{row: hit_row_s, col: col_idx_r + 3'd1};
        end else begin
            scan_s = cand_r;
        end
    end

    assign eos_s = run_r && (state_r == SAMPLE) && (col_idx_r == COL_LAST);

    // Column sequencing: settle counter, column index and per-scan candidate.
    always_comb begin
        state_s   = state_r;
        settle_s  = settle_r;
        col_idx_s = col_idx_r;
        cand_s    = cand_r;
        if (!run_r) begin
            state_s   = DRIVE;
            settle_s  = '0;
            col_idx_s = 3'd0;
            cand_s    = CODE_PAIR_NONE;
        end else begin
            case (state_r)
                DRIVE: begin
                    if (settle_r == SETTLE_LAST) begin
                        state_s  = SAMPLE;
                        settle_s = '0;
                    end else begin
                        state_s  = DRIVE;
                        settle_s = settle_r + SET_W'(1);
                    end
                end
                SAMPLE: begin
                    state_s = DRIVE;
                    if (col_idx_r == COL_LAST) begin
                        col_idx_s = 3'd0;
                        cand_s    = CODE_PAIR_NONE;
                    end else begin
                        col_idx_s = col_idx_r + 3'd1;
                        cand_s    = scan_s;
                    end
                end
                default: begin
                    state_s   = DRIVE;
                    settle_s  = '0;
                    col_idx_s = 3'd0;
                    cand_s    = CODE_PAIR_NONE;
                end
            endcase
        end
        col_out_s = col_onehot(col_idx_s);
    end

    // Debounce at end of scan and the code handshake; acceptance is applied before a new load.
    always_comb begin
        prev_s       = prev_r;
        stable_s     = stable_r;
        reported_s   = reported_r;
        code_s       = code_r;
        key_down_s   = key_down_r;
        overflow_s   = 1'b0;
        code_valid_s = code_valid_r & ~code_ready;
        if (eos_s) begin
            prev_s = scan_s;
            if (scan_s == prev_r) begin
                stable_s = (stable_r == DEB_MAX) ? DEB_MAX : stable_r + DEB_W'(1);
            end else begin
                stable_s = DEB_W'(1);
            end
            if (stable_s == DEB_MAX && scan_s != reported_r) begin
                reported_s = scan_s;
                if (scan_s.row != CODE_NONE) begin
                    key_down_s = 1'b1;
                    if (!code_valid_s) begin
                        code_s       = scan_s;
                        code_valid_s = 1'b1;
                    end else begin
                        overflow_s = 1'b1;
                    end
                end else begin
                    key_down_s = 1'b0;
                end
            end else begin
                reported_s = reported_r;
            end
        end else begin
            prev_s = prev_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= DRIVE;
            run_r        <= 1'b0;
            settle_r     <= '0;
            col_idx_r    <= 3'd0;
            col_out_r    <= '0;
            cand_r       <= CODE_PAIR_NONE;
            prev_r       <= CODE_PAIR_NONE;
            stable_r     <= '0;
            reported_r   <= CODE_PAIR_NONE;
            code_r       <= CODE_PAIR_NONE;
            code_valid_r <= 1'b0;
            key_down_r   <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            run_r        <= 1'b1;
            settle_r     <= settle_s;
            col_idx_r    <= col_idx_s;
            col_out_r    <= col_out_s;
            cand_r       <= cand_s;
            prev_r       <= prev_s;
            stable_r     <= stable_s;
            reported_r   <= reported_s;
            code_r       <= code_s;
            code_valid_r <= code_valid_s;
            key_down_r   <= key_down_s;
            overflow_r   <= overflow_s;
        end
    end

    assign col_out    = col_out_r;
    assign code_row   = code_r.row;
    assign code_col   = code_r.col;
    assign code_valid = code_valid_r;
    assign key_down   = key_down_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_matriz_scanner.sv
// Self-checking bench for matriz_scanner: a key-matrix model, a code scoreboard,
// a table of single/multi-key presses and hand-written multi-cycle sequences.
module tb_matriz_scanner;
    import matriz_pkg::*;

    localparam int NC = 5;
    localparam int NR = 7;
    localparam int P  = 25;
    localparam int WAIT_MAX = 4 * P + 10;

    typedef struct {
        logic [NC*NR-1:0] keys;
        logic [2:0]       exp_row;
        logic [2:0]       exp_col;
    } vec_t;

    logic          clk;
    logic          reset;
    logic [NR-1:0] row_in;
    logic [NC-1:0] col_out;
    logic [2:0]    code_row;
    logic [2:0]    code_col;
    logic          code_valid;
    logic          code_ready;
    logic          key_down;
    logic          overflow;

    logic [NC*NR-1:0] keys;
    code_pair_t       exp_q[$];
    int               total;
    int               bad;
    int               ovf_cnt;
    logic             saw_valid;
    vec_t             vecs[6];

    matriz_scanner #(
        .N_COLS(NC), .N_ROWS(NR), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .row_in     (row_in),
        .col_out    (col_out),
        .code_row   (code_row),
        .code_col   (code_col),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .key_down   (key_down),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a pressed key connects its column drive to its row line.
    always_comb begin
        row_in = '0;
        for (int c = 0; c < NC; c++) begin
            if (col_out[c]) begin
                row_in = row_in | keys[c*NR +: NR];
            end
        end
    end

    function automatic logic [NC*NR-1:0] kb(input int c, input int r);
        logic [NC*NR-1:0] v;
        v = '0;
        v[c*NR + r] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Samples mid-cycle (handshake scoreboard, overflow count), then advances one clock.
    task automatic step();
        code_pair_t e;
        #3;
        if (overflow === 1'b1) ovf_cnt++;
        if (code_valid === 1'b1 && code_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_code got row=%0d col=%0d", code_row, code_col);
            end else begin
                e = exp_q.pop_front();
                if (code_row !== e.row || code_col !== e.col) begin
                    bad++;
                    $display("FAIL code_value got row=%0d col=%0d exp row=%0d col=%0d",
                             code_row, code_col, e.row, e.col);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {col_out, code_row, code_col, code_valid, key_down, overflow}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_outputs");
        step();
        step();
        check_outputs_zero("reset_held_outputs");
        reset = 1'b0;
    endtask

    // Must be entered right after reset release: checks the column walk and quiet outputs.
    task automatic idle_check(input int scans);
        for (int s = 0; s < scans; s++) begin
            for (int c = 0; c < NC; c++) begin
                for (int k = 0; k < 5; k++) begin
                    step();
                    check("idle_col_out", {27'd0, col_out}, 32'd1 << c);
                    check("idle_quiet", {30'd0, code_valid, key_down}, 32'd0);
                end
            end
        end
    endtask

    task automatic release_keys();
        keys = '0;
        for (int n = 0; n < WAIT_MAX && key_down; n++) step();
        check("release_key_down", {31'd0, key_down}, 32'd0);
        steps(P);
    endtask

    task automatic wait_delivered(input string name);
        for (int n = 0; n < WAIT_MAX && exp_q.size() != 0; n++) step();
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        total = 0; bad = 0; ovf_cnt = 0;
        keys = '0; code_ready = 1'b1; reset = 1'b1;
        vecs[0] = '{kb(2, 4),            3'd5, 3'd3};
        vecs[1] = '{kb(0, 0) | kb(3, 6), 3'd1, 3'd1};
        vecs[2] = '{kb(4, 6),            3'd7, 3'd5};
        vecs[3] = '{kb(1, 3) | kb(1, 5), 3'd4, 3'd2};
        vecs[4] = '{kb(3, 0) | kb(2, 6), 3'd7, 3'd3};
        vecs[5] = '{kb(0, 6),            3'd7, 3'd1};

        @(posedge clk);
        #1;
        do_reset();
        idle_check(2);

        // Exact latency: key held from before reset release; valid rises in cycle 76.
        keys = kb(2, 4);
        exp_q.push_back('{row: 3'd5, col: 3'd3});
        do_reset();
        for (int i = 1; i <= 76; i++) begin
            step();
            if (i == 75) check("latency_before", {30'd0, code_valid, key_down}, 32'd0);
            if (i == 76) begin
                check("latency_valid", {31'd0, code_valid}, 32'd1);
                check("latency_key_down", {31'd0, key_down}, 32'd1);
                check("latency_code", {26'd0, code_row, code_col}, {26'd0, 3'd5, 3'd3});
            end
        end
        steps(2 * P);
        check("latency_delivered", exp_q.size(), 32'd0);
        release_keys();

        for (int v = 0; v < 6; v++) begin
            keys = vecs[v].keys;
            exp_q.push_back('{row: vecs[v].exp_row, col: vecs[v].exp_col});
            wait_delivered("vec_delivered");
            steps(3 * P);
            check("vec_key_down", {31'd0, key_down}, 32'd1);
            release_keys();
        end

        // Bounce for two scans, then hold: one code only after it settles.
        saw_valid = 1'b0;
        keys = kb(2, 4);
        for (int n = 0; n < 48; n++) begin
            if (n % 7 == 0 && n != 0) keys = keys ^ kb(2, 4);
            step();
            if (code_valid) saw_valid = 1'b1;
        end
        check("bounce_no_code", {31'd0, saw_valid}, 32'd0);
        keys = kb(2, 4);
        exp_q.push_back('{row: 3'd5, col: 3'd3});
        wait_delivered("bounce_delivered");
        steps(3 * P);
        release_keys();

        // Consumer stalled: A pending, direct switch to B overflows once, A then delivered.
        code_ready = 1'b0;
        ovf_cnt = 0;
        keys = kb(1, 1);
        exp_q.push_back('{row: 3'd2, col: 3'd2});
        for (int n = 0; n < WAIT_MAX && !code_valid; n++) step();
        check("ovf_a_valid", {31'd0, code_valid}, 32'd1);
        check("ovf_a_code", {26'd0, code_row, code_col}, {26'd0, 3'd2, 3'd2});
        keys = kb(3, 2);
        for (int n = 0; n < WAIT_MAX && ovf_cnt == 0; n++) step();
        check("ovf_pulse", ovf_cnt, 32'd1);
        check("ovf_a_held", {25'd0, code_valid, code_row, code_col}, {25'd0, 1'b1, 3'd2, 3'd2});
        check("ovf_key_down", {31'd0, key_down}, 32'd1);
        steps(2 * P);
        check("ovf_once", ovf_cnt, 32'd1);
        code_ready = 1'b1;
        wait_delivered("ovf_a_delivered");
        steps(2 * P);
        check("ovf_after_valid", {31'd0, code_valid}, 32'd0);
        release_keys();

        // Reset while a code is pending and a new key is mid-debounce.
        code_ready = 1'b0;
        keys = kb(0, 3);
        exp_q.push_back('{row: 3'd4, col: 3'd1});
        for (int n = 0; n < WAIT_MAX && !code_valid; n++) step();
        check("pre_reset_valid", {31'd0, code_valid}, 32'd1);
        keys = kb(4, 1);
        steps(30);
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset_async");
        exp_q.delete();
        step();
        check_outputs_zero("midreset_edge");
        keys = '0;
        code_ready = 1'b1;
        reset = 1'b0;
        idle_check(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matriz_scanner.md
# matriz_scanner

Scans a 5-column × 7-row push-button matrix and turns the first pressed key into a pair of non-zero 3-bit codes, row and column. This block is the input side of the dot-matrix path. The display decoder consumes two 3-bit codes and lights rows. This scanner produces the same two 3-bit code fields from a physical matrix, with debounce and a valid/ready handshake. It sits between the board's key-matrix pins and the control logic that feeds the display decoder.

## Interface
- `N_COLS`, default 5: number of driven column lines. Must be 1..7.
- `N_ROWS`, default 7: number of sensed row lines. Must be 1..7.
- `SETTLE_CYCLES`, default 4: cycles a column is driven before its rows are sampled. Must be ≥ 3 to cover the 2-flop synchronizer.
- `DEBOUNCE_SCANS`, default 3: number of consecutive identical full scans required before a state change is accepted. Must be ≥ 1.
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `row_in`, in, N_ROWS: raw row lines, active-high, asynchronous to `clk`.
- `col_out`, out, N_COLS: column drive, one-hot active-high.
- `code_row`, out, 3: pressed row as index+1 (1..N_ROWS). Value 0 means none.
- `code_col`, out, 3: pressed column as index+1 (1..N_COLS). Value 0 means none.
- `code_valid`, out, 1: the code pair is presented.
- `code_ready`, in, 1: the consumer accepts the code.
- `key_down`, out, 1: the debounced state is "a key is held".
- `overflow`, out, 1: one-cycle pulse when a new press is dropped.

## Operation
- `row_in` passes through a 2-flop synchronizer before any use.
- FSM states:
  - RESET_IDLE: present only while `reset` is high.
  - DRIVE: the column counter `col_idx` is asserted on `col_out` and the settle counter runs 0..SETTLE_CYCLES-1.
  - SAMPLE: one cycle. Read the synchronized rows, update the scan candidate, advance `col_idx`.
- Transitions:
  - DRIVE → SAMPLE when the settle counter reaches its end.
  - SAMPLE → DRIVE always.
  - `col_idx` wraps from N_COLS-1 to 0. That wrap marks end-of-scan.
- Scan candidate: the first active key in (lowest column, then lowest row) order. The candidate is {0,0} if no key is active. It is reset to {0,0} at the start of each scan.
- At end-of-scan, compare the candidate with the previous scan's candidate:
  - If they are equal, the stable counter increments, saturating at DEBOUNCE_SCANS.
  - If they differ, the stable counter goes to 1.
- When the stable counter reaches DEBOUNCE_SCANS and the candidate differs from `reported`:
  - Non-zero candidate: `reported` ← candidate and `key_down` ← 1.
    - If `code_valid` is low, load `code_row`/`code_col` and set `code_valid`.
    - Otherwise pulse `overflow` and drop the code.
  - Zero candidate: `reported` ← {0,0} and `key_down` ← 0. This is a release and emits no code.
- Handshake: `code_valid` stays high and the codes stay stable until a cycle with `code_valid && code_ready`.
  - After that handshake cycle `code_valid` is low.
  - The codes hold their last value.
- A key held continuously is reported once. Re-reporting the same key needs a debounced release first.
- Switching directly from one held key to another is a new report. No release is needed in between.

## Timing
- Reset values:
  - `col_out`, `code_row`, `code_col`, `code_valid`, `key_down`, `overflow`: all 0.
  - `col_idx`, counters, `reported`, synchronizer: all 0.
- First cycle after reset deasserts: DRIVE, column 0, `col_out`=1.
- Each column occupies SETTLE_CYCLES+1 cycles. Scan period P = N_COLS·(SETTLE_CYCLES+1), which is 25 cycles at the defaults.
- `code_valid` rises the cycle after the SAMPLE that ends the DEBOUNCE_SCANS-th stable scan.
  - Worst case from the press edge: (DEBOUNCE_SCANS+1)·P + 3 cycles.
- End-of-scan debounce decision and handshake acceptance in the same cycle: acceptance takes effect first. The new code loads, `code_valid` stays high, and there is no overflow.
- `reset` mid-scan: all state clears immediately (asynchronously). The scan restarts at column 0 and any pending code is discarded.

## Structure
- A shared package `matriz_pkg` holds:
  - `CODE_W`=3 and `CODE_NONE`=3'd0.
  - The FSM state enum `{DRIVE, SAMPLE}`.
  - A code-pair struct `{row, col}` used by both this scanner and the display decoder's inputs.
- Sub-module `matriz_sync2`: parameterized-width 2-flop synchronizer.
- The FSM, counters, priority encoder, debounce and handshake stay in the top module.

## Test plan
- Reset, idle:
  - `col_out` sequences 1, 2, 4, 8, 16, each for 5 cycles.
  - `code_valid` never rises and `key_down`=0.
- Hold key at column 2, row 4 for 5 scans with `code_ready`=1:
  - One handshake with `code_col`=3, `code_row`=5.
  - `key_down`=1 after scan 3.
- Press column 0 row 0 and column 3 row 6 together:
  - Reports `code_col`=1, `code_row`=1 only.
- Key bounces (toggling every 7 cycles) for 2 scans, then held:
  - No code during the bounce.
  - Exactly one code 3 stable scans after bouncing stops.
- `code_ready`=0 with press A, then a direct switch to press B:
  - A is held on the outputs.
  - `overflow` pulses once when B is accepted.
  - After `code_ready`=1, A is delivered and B is not.
- `reset` asserted mid-debounce with `code_valid` high:
  - All outputs are 0 on the next edge.
  - The scan restarts at `col_out`=1.
